// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// digit count, blank/off patterns and the active-low hex glyph table.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Indexed by nibble value; bit0 = segment a ... bit6 = segment g, 0 = lit.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to 7-segment (active-low) decoder driven by the
// shared glyph table.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed 8-digit hex display driver with frame-synchronous input
// snapshot, per-slot anode blanking gap and optional leading-zero blanking.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_in,
  input  logic [14:0] pc_in,
  input  logic        show_pc,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [31:0]      BLANK_U  = 32'(BLANK_CYCLES);
  localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       dig;
  logic [31:0]      shadow;
  logic             mode_q;
  logic             lz_q;

  logic             cnt_wrap;
  logic             frame_end;
  logic             in_gap;
  logic [3:0]       nib;
  logic [31:0]      upper;
  logic             lz_blank;
  logic [6:0]       seg_hex;

  logic [6:0]       seg_d;
  logic [7:0]       an_d;
  logic             dp_d;

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_end = cnt_wrap && (dig == DIG_LAST);
  assign in_gap    = (32'(cnt) < BLANK_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dig <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      dig <= dig + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Inputs are captured only on the last cycle of digit 7 so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      mode_q <= 1'b0;
      lz_q   <= 1'b0;
    end else if (frame_end) begin
      shadow <= show_pc ? {17'b0, pc_in} : value_in;
      mode_q <= show_pc;
      lz_q   <= blank_lz;
    end
  end

  assign nib      = shadow[{dig, 2'b00} +: 4];
  assign upper    = shadow >> {dig, 2'b00};
  // Digit 0 is exempt so an all-zero word still shows a single "0".
  assign lz_blank = lz_q && (dig != 3'd0) && (upper == 32'd0);

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (seg_hex)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (!in_gap) begin
      an_d  = ~(8'b1 << dig);
      seg_d = lz_blank ? SEG_BLANK : seg_hex;
      dp_d  = ~(mode_q && (dig == 3'd0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_BLANK;
      an_n  <= AN_OFF;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_d;
      an_n  <= an_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: directed display scenarios plus random input
// churn, checked every cycle against an edge-numbered behavioural model.
module tb_seg_display_driver;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = 8 * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value_in = '0;
  logic [14:0] pc_in = '0;
  logic        show_pc = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;

  int checks = 0;
  int failures = 0;

  // Model state: edge number since reset release and the frame snapshot.
  int          k = 0;
  logic [31:0] m_shadow = '0;
  logic        m_mode = 1'b0;
  logic        m_lz = 1'b0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_display_driver #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .pc_in    (pc_in),
    .show_pc  (show_pc),
    .blank_lz (blank_lz),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // What the display should show after edge k, given the snapshot in force.
  task automatic model_expect(output logic [7:0] e_an, output logic [6:0] e_seg,
                              output logic e_dp);
    int p;
    int d;
    logic [31:0] up;
    p = (k - 1) % R;
    d = ((k - 1) / R) % 8;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    if (p >= B) begin
      up    = m_shadow >> (4 * d);
      e_an  = ~(8'(1) << d);
      e_seg = (m_lz && d != 0 && up == 0) ? 7'h7F : glyph[up[3:0]];
      e_dp  = (m_mode && d == 0) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic step();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    k++;
    model_expect(e_an, e_seg, e_dp);
    if (k % FRAME == 0) begin
      m_shadow = show_pc ? {17'b0, pc_in} : value_in;
      m_mode   = show_pc;
      m_lz     = blank_lz;
    end
    #1;
    check("an_n", 32'(an_n), 32'(e_an));
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dp));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Stop with the next edge being a frame boundary.
  task automatic run_to_boundary();
    int guard = 0;
    while ((k + 1) % FRAME != 0 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    k        = 0;
    m_shadow = '0;
    m_mode   = 1'b0;
    m_lz     = 1'b0;
  endtask

  task automatic set_inputs(input logic [31:0] v, input logic [14:0] pc,
                            input logic sp, input logic lz);
    value_in = v; pc_in = pc; show_pc = sp; blank_lz = lz;
  endtask

  initial begin
    int guard;
    int d;
    int p;

    // Reset state while held.
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an_n), 32'h FF);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dp", 32'(dp_n), 32'h1);

    // Value mode from reset: frame 0 shows zeros, frame 1 the snapshot.
    set_inputs(32'h1234ABCD, 15'h0, 1'b0, 1'b0);
    release_reset();
    run(2 * FRAME);

    // Leading-zero blanking.
    run_to_boundary();
    set_inputs(32'h0000_00A0, 15'h0, 1'b0, 1'b1);
    run(2 * FRAME);
    run_to_boundary();
    set_inputs(32'h0, 15'h0, 1'b0, 1'b1);
    run(2 * FRAME);

    // PC mode with decimal point on digit 0.
    run_to_boundary();
    set_inputs(32'hDEAD_BEEF, 15'h7FFF, 1'b1, 1'b1);
    run(2 * FRAME);

    // No tearing: mid-frame change waits for the next boundary.
    run_to_boundary();
    set_inputs(32'h1111_1111, 15'h0, 1'b0, 1'b0);
    run(FRAME + 13);
    value_in = 32'h2222_2222;
    run_to_boundary();
    run(FRAME);
    // Change presented right before the boundary edge is captured.
    run_to_boundary();
    value_in = 32'h3333_3333;
    run(FRAME + 2);

    // Random churn.
    for (int i = 0; i < 30 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value_in = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
        pc_in    = 15'($urandom);
        show_pc  = 1'($urandom_range(0, 1));
        blank_lz = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Reset mid-slot during digit 5 active.
    guard = 0;
    d = -1;
    p = -1;
    while (!(d == 5 && p == 2) && guard < 2 * FRAME) begin
      step();
      d = ((k - 1) / R) % 8;
      p = (k - 1) % R;
      guard++;
    end
    check("reach_dig5", 32'(d), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(an_n), 32'hFF);
    check("async_seg", 32'(seg_n), 32'h7F);
    check("async_dp", 32'(dp_n), 32'h1);
    set_inputs(32'h9876_5432, 15'h1234, 1'b0, 1'b0);
    release_reset();
    run(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
